// File: rtl/issueq_pkg.sv
// Shared definitions for the in-order issue queue.
// Opcode classes, per-slot flag bundle and the operand-need decoder.
package issueq_pkg;

  localparam logic [1:0] OP_NONE   = 2'b00;
  localparam logic [1:0] OP_RS1    = 2'b01;
  localparam logic [1:0] OP_RS1RS2 = 2'b10;

  typedef struct packed {
    logic rs1;
    logic rs2;
  } iq_need_t;

  typedef struct packed {
    logic valid;
    logic rs1_rdy;
    logic rs2_rdy;
  } iq_flags_t;

  function automatic iq_need_t op_need(
    input logic [1:0] op
  );
    iq_need_t n;
    n = '0;
    unique case (1'b1)
      (op == OP_RS1RS2): begin
        n.rs1 = 1'b1;
        n.rs2 = 1'b1;
      end
      (op == OP_RS1):    n.rs1 = 1'b1;
      default:           n = '0;
    endcase
    return n;
  endfunction

endpackage

// File: rtl/issue_queue_param_if.sv
// Dispatch / CDB / issue bundle of the issue queue.
// master = producer/consumer side, slave = the queue itself.
interface issue_queue_param_if #(
  parameter int DATA_W = 32,
  parameter int TAG_W  = 6,
  parameter int OP_W   = 2,
  parameter int CNT_W  = 3
);
  logic              dispatch_valid;
  logic              dispatch_ready;
  logic [OP_W-1:0]   dispatch_opcode;
  logic [TAG_W-1:0]  dispatch_rd_tag;
  logic [TAG_W-1:0]  dispatch_rs1_tag;
  logic [TAG_W-1:0]  dispatch_rs2_tag;
  logic [DATA_W-1:0] dispatch_rs1_data;
  logic [DATA_W-1:0] dispatch_rs2_data;
  logic              dispatch_rs1_data_val;
  logic              dispatch_rs2_data_val;
  logic [DATA_W-1:0] dispatch_imm;
  logic              CDB_valid;
  logic [TAG_W-1:0]  CDB_tag;
  logic [DATA_W-1:0] CDB_data;
  logic              issue_valid;
  logic              issue_ready;
  logic [OP_W-1:0]   issue_opcode;
  logic [TAG_W-1:0]  issue_rd_tag;
  logic [DATA_W-1:0] issue_rs1_data;
  logic [DATA_W-1:0] issue_rs2_data;
  logic [DATA_W-1:0] issue_imm_data;
  logic [CNT_W-1:0]  count;
  logic              full;
  logic              empty;

  modport master (
    output dispatch_valid, dispatch_opcode,
    output dispatch_rd_tag,
    output dispatch_rs1_tag, dispatch_rs2_tag,
    output dispatch_rs1_data, dispatch_rs2_data,
    output dispatch_rs1_data_val,
    output dispatch_rs2_data_val,
    output dispatch_imm,
    output CDB_valid, CDB_tag, CDB_data,
    output issue_ready,
    input  dispatch_ready, issue_valid,
    input  issue_opcode, issue_rd_tag,
    input  issue_rs1_data, issue_rs2_data,
    input  issue_imm_data,
    input  count, full, empty
  );

  modport slave (
    input  dispatch_valid, dispatch_opcode,
    input  dispatch_rd_tag,
    input  dispatch_rs1_tag, dispatch_rs2_tag,
    input  dispatch_rs1_data, dispatch_rs2_data,
    input  dispatch_rs1_data_val,
    input  dispatch_rs2_data_val,
    input  dispatch_imm,
    input  CDB_valid, CDB_tag, CDB_data,
    input  issue_ready,
    output dispatch_ready, issue_valid,
    output issue_opcode, issue_rd_tag,
    output issue_rs1_data, issue_rs2_data,
    output issue_imm_data,
    output count, full, empty
  );
endinterface

// File: rtl/issueq_entry.sv
// One issue-queue slot: write port, CDB wakeup/capture, ready flag.
// Ports: clk/reset/flush, we+wr_*, clr (dequeue), cdb_*, slot fields out.
module issueq_entry
  import issueq_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int TAG_W  = 6,
  parameter int OP_W   = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              we,
  input  logic              clr,
  input  logic [OP_W-1:0]   wr_opcode,
  input  logic [TAG_W-1:0]  wr_rd_tag,
  input  logic [TAG_W-1:0]  wr_rs1_tag,
  input  logic [TAG_W-1:0]  wr_rs2_tag,
  input  logic [DATA_W-1:0] wr_rs1_data,
  input  logic [DATA_W-1:0] wr_rs2_data,
  input  logic              wr_rs1_val,
  input  logic              wr_rs2_val,
  input  logic [DATA_W-1:0] wr_imm,
  input  logic              cdb_valid,
  input  logic [TAG_W-1:0]  cdb_tag,
  input  logic [DATA_W-1:0] cdb_data,
`ifdef ISSUEQ_ISSUE_BYPASS_EN
  output logic              rs1_hit,
  output logic              rs2_hit,
`endif
  output iq_flags_t         flags,
  output logic              ready,
  output logic [OP_W-1:0]   opcode,
  output logic [TAG_W-1:0]  rd_tag,
  output logic [DATA_W-1:0] rs1_data,
  output logic [DATA_W-1:0] rs2_data,
  output logic [DATA_W-1:0] imm
);

  typedef struct packed {
    iq_flags_t         f;
    logic [OP_W-1:0]   opcode;
    logic [TAG_W-1:0]  rd_tag;
    logic [TAG_W-1:0]  rs1_tag;
    logic [TAG_W-1:0]  rs2_tag;
    logic [DATA_W-1:0] rs1_data;
    logic [DATA_W-1:0] rs2_data;
    logic [DATA_W-1:0] imm;
  } slot_t;

  slot_t    slot_q, slot_d;
  logic     hit1, hit2, whit1, whit2;
  iq_need_t nd;

  assign hit1  = cdb_valid && slot_q.f.valid
              && !slot_q.f.rs1_rdy
              && (cdb_tag == slot_q.rs1_tag);
  assign hit2  = cdb_valid && slot_q.f.valid
              && !slot_q.f.rs2_rdy
              && (cdb_tag == slot_q.rs2_tag);
  assign whit1 = cdb_valid && !wr_rs1_val
              && (cdb_tag == wr_rs1_tag);
  assign whit2 = cdb_valid && !wr_rs2_val
              && (cdb_tag == wr_rs2_tag);

  always_comb begin
    slot_d = slot_q;
    if (we) begin
      slot_d.f.valid   = 1'b1;
      slot_d.opcode    = wr_opcode;
      slot_d.rd_tag    = wr_rd_tag;
      slot_d.rs1_tag   = wr_rs1_tag;
      slot_d.rs2_tag   = wr_rs2_tag;
      slot_d.imm       = wr_imm;
      slot_d.f.rs1_rdy = wr_rs1_val | whit1;
      slot_d.f.rs2_rdy = wr_rs2_val | whit2;
      slot_d.rs1_data  = whit1 ? cdb_data
                               : wr_rs1_data;
      slot_d.rs2_data  = whit2 ? cdb_data
                               : wr_rs2_data;
    end else if (!clr) begin
      if (hit1) begin
        slot_d.f.rs1_rdy = 1'b1;
        slot_d.rs1_data  = cdb_data;
      end
      if (hit2) begin
        slot_d.f.rs2_rdy = 1'b1;
        slot_d.rs2_data  = cdb_data;
      end
    end
    if (clr || flush) slot_d.f.valid = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (reset) slot_q <= '0;
    else       slot_q <= slot_d;
  end

  assign nd    = op_need(slot_q.opcode[1:0]);
  assign ready = slot_q.f.valid
              && (!nd.rs1 || slot_q.f.rs1_rdy)
              && (!nd.rs2 || slot_q.f.rs2_rdy);

`ifdef ISSUEQ_ISSUE_BYPASS_EN
  assign rs1_hit = hit1;
  assign rs2_hit = hit2;
`endif
  assign flags    = slot_q.f;
  assign opcode   = slot_q.opcode;
  assign rd_tag   = slot_q.rd_tag;
  assign rs1_data = slot_q.rs1_data;
  assign rs2_data = slot_q.rs2_data;
  assign imm      = slot_q.imm;

endmodule

// File: rtl/issue_queue_param.sv
// In-order issue queue: DEPTH slots, CDB wakeup, head-only issue.
// Ports: clk, reset, flush, io (slave). Option: ISSUEQ_ISSUE_BYPASS_EN.
module issue_queue_param
  import issueq_pkg::*;
#(
  parameter int DEPTH  = 4,
  parameter int DATA_W = 32,
  parameter int TAG_W  = 6,
  parameter int OP_W   = 2
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 flush,
  issue_queue_param_if.slave   io
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [PW-1:0] head_q, head_d;
  logic [PW-1:0] tail_q, tail_d;
  logic [CW-1:0] count_q, count_d;
  logic          full, enq, deq;

  iq_flags_t         e_flags [DEPTH];
  logic              e_ready [DEPTH];
  logic [OP_W-1:0]   e_op    [DEPTH];
  logic [TAG_W-1:0]  e_rd    [DEPTH];
  logic [DATA_W-1:0] e_rs1   [DEPTH];
  logic [DATA_W-1:0] e_rs2   [DEPTH];
  logic [DATA_W-1:0] e_imm   [DEPTH];
`ifdef ISSUEQ_ISSUE_BYPASS_EN
  logic              e_hit1  [DEPTH];
  logic              e_hit2  [DEPTH];
`endif

  assign full = (count_q == CW'(DEPTH));
  assign enq  = io.dispatch_valid && !full;
  assign deq  = io.issue_valid && io.issue_ready;

  for (genvar i = 0; i < DEPTH; i++) begin : g_slot
    issueq_entry #(
      .DATA_W (DATA_W),
      .TAG_W  (TAG_W),
      .OP_W   (OP_W)
    ) u_entry (
      .clk         (clk),
      .reset       (reset),
      .flush       (flush),
      .we          (enq && !flush
                    && (tail_q == PW'(i))),
      .clr         (deq && (head_q == PW'(i))),
      .wr_opcode   (io.dispatch_opcode),
      .wr_rd_tag   (io.dispatch_rd_tag),
      .wr_rs1_tag  (io.dispatch_rs1_tag),
      .wr_rs2_tag  (io.dispatch_rs2_tag),
      .wr_rs1_data (io.dispatch_rs1_data),
      .wr_rs2_data (io.dispatch_rs2_data),
      .wr_rs1_val  (io.dispatch_rs1_data_val),
      .wr_rs2_val  (io.dispatch_rs2_data_val),
      .wr_imm      (io.dispatch_imm),
      .cdb_valid   (io.CDB_valid),
      .cdb_tag     (io.CDB_tag),
      .cdb_data    (io.CDB_data),
`ifdef ISSUEQ_ISSUE_BYPASS_EN
      .rs1_hit     (e_hit1[i]),
      .rs2_hit     (e_hit2[i]),
`endif
      .flags       (e_flags[i]),
      .ready       (e_ready[i]),
      .opcode      (e_op[i]),
      .rd_tag      (e_rd[i]),
      .rs1_data    (e_rs1[i]),
      .rs2_data    (e_rs2[i]),
      .imm         (e_imm[i])
    );
  end

  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (flush) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else begin
      if (enq) tail_d = tail_q + 1'b1;
      if (deq) head_d = head_q + 1'b1;
      unique case ({enq, deq})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

`ifdef ISSUEQ_ISSUE_BYPASS_EN
  iq_need_t nd;
  logic     ok1, ok2;
  assign nd  = op_need(e_op[head_q][1:0]);
  assign ok1 = e_flags[head_q].rs1_rdy
            || e_hit1[head_q];
  assign ok2 = e_flags[head_q].rs2_rdy
            || e_hit2[head_q];
  // Head operand still waiting but on the bus now: forward it.
  assign io.issue_valid =
    e_ready[head_q]
    || (e_flags[head_q].valid
        && (!nd.rs1 || ok1)
        && (!nd.rs2 || ok2));
  assign io.issue_rs1_data =
    e_hit1[head_q] ? io.CDB_data : e_rs1[head_q];
  assign io.issue_rs2_data =
    e_hit2[head_q] ? io.CDB_data : e_rs2[head_q];
`else
  assign io.issue_valid    = e_ready[head_q];
  assign io.issue_rs1_data = e_rs1[head_q];
  assign io.issue_rs2_data = e_rs2[head_q];
`endif

  assign io.issue_opcode   = e_op[head_q];
  assign io.issue_rd_tag   = e_rd[head_q];
  assign io.issue_imm_data = e_imm[head_q];
  assign io.count          = count_q;
  assign io.full           = full;
  assign io.empty          = (count_q == '0);
  assign io.dispatch_ready = !full;

endmodule

// File: tb/tb_issue_queue_param.sv
// Directed self-checking bench for issue_queue_param (DEPTH=4).
// Immediate assertions at each check point; one summary line.
module tb_issue_queue_param;

  logic clk = 1'b0;
  logic reset;
  logic flush;
  int   n_cmp = 0;
  int   n_err = 0;
  int   q[$];
  int   nxt;
  logic acc;

  always #5 clk = ~clk;

  issue_queue_param_if #(
    .DATA_W (32), .TAG_W (6), .OP_W (2), .CNT_W (3)
  ) bus ();

  issue_queue_param #(
    .DEPTH (4), .DATA_W (32), .TAG_W (6), .OP_W (2)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .flush (flush),
    .io    (bus)
  );

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h",
             tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic disp(input logic [1:0] op,
                      input logic [5:0] rd,
                      input logic [5:0] t1,
                      input logic [31:0] d1,
                      input logic v1,
                      input logic [5:0] t2,
                      input logic [31:0] d2,
                      input logic v2);
    bus.dispatch_valid        = 1'b1;
    bus.dispatch_opcode       = op;
    bus.dispatch_rd_tag       = rd;
    bus.dispatch_rs1_tag      = t1;
    bus.dispatch_rs1_data     = d1;
    bus.dispatch_rs1_data_val = v1;
    bus.dispatch_rs2_tag      = t2;
    bus.dispatch_rs2_data     = d2;
    bus.dispatch_rs2_data_val = v2;
    bus.dispatch_imm          = 32'h0;
  endtask

  task automatic cdb(input logic v,
                     input logic [5:0] t,
                     input logic [31:0] d);
    bus.CDB_valid = v;
    bus.CDB_tag   = t;
    bus.CDB_data  = d;
  endtask

  task automatic drain1();
    bus.issue_ready = 1'b1;
    tick();
    bus.issue_ready = 1'b0;
    #1;
  endtask

  initial begin
    reset = 1'b1;
    flush = 1'b0;
    disp(2'b00, 0, 0, 0, 0, 0, 0, 0);
    bus.dispatch_valid = 1'b0;
    cdb(1'b0, 0, 0);
    bus.issue_ready = 1'b0;
    tick();
    tick();
    reset = 1'b0;
    #1;
    chk("rst_count", bus.count, 0);
    chk("rst_empty", bus.empty, 1);
    chk("rst_full", bus.full, 0);
    chk("rst_dready", bus.dispatch_ready, 1);
    chk("rst_ivalid", bus.issue_valid, 0);
    chk("rst_rs1", bus.issue_rs1_data, 0);

    // 1: both operands ready
    disp(2'b10, 3, 1, 5, 1, 2, 7, 1);
    tick();
    bus.dispatch_valid = 1'b0;
    #1;
    chk("t1_ivalid", bus.issue_valid, 1);
    chk("t1_rs1", bus.issue_rs1_data, 5);
    chk("t1_rs2", bus.issue_rs2_data, 7);
    chk("t1_rd", bus.issue_rd_tag, 3);
    chk("t1_count", bus.count, 1);
    drain1();
    chk("t1_empty", bus.empty, 1);
    chk("t1_count0", bus.count, 0);

    // 2: rs2 waits on tag 9
    disp(2'b10, 4, 1, 1, 1, 9, 0, 0);
    tick();
    bus.dispatch_valid = 1'b0;
    #1;
    chk("t2_wait", bus.issue_valid, 0);
    cdb(1'b1, 9, 32'h55);
    #1;
`ifdef ISSUEQ_ISSUE_BYPASS_EN
    chk("t2_byp_v", bus.issue_valid, 1);
    chk("t2_byp_d", bus.issue_rs2_data, 32'h55);
`else
    chk("t2_same", bus.issue_valid, 0);
`endif
    tick();
    cdb(1'b0, 0, 0);
    #1;
    chk("t2_wake_v", bus.issue_valid, 1);
    chk("t2_wake_d", bus.issue_rs2_data, 32'h55);
    chk("t2_rs1", bus.issue_rs1_data, 1);
    drain1();
    chk("t2_empty", bus.empty, 1);

    // 3: capture at dispatch
    disp(2'b01, 6, 12, 0, 0, 0, 0, 0);
    cdb(1'b1, 12, 32'hAA);
    tick();
    bus.dispatch_valid = 1'b0;
    cdb(1'b0, 0, 0);
    #1;
    chk("t3_v", bus.issue_valid, 1);
    chk("t3_rs1", bus.issue_rs1_data, 32'hAA);
    drain1();

    // 4: fill past full, then wrap
    for (int i = 0; i < 5; i++) begin
      disp(2'b00, 6'(10 + i), 0, 0, 0, 0, 0, 0);
      #1;
      chk("t4_dready", bus.dispatch_ready,
          (i < 4) ? 1 : 0);
      tick();
    end
    bus.dispatch_valid = 1'b0;
    #1;
    chk("t4_full", bus.full, 1);
    chk("t4_count", bus.count, 4);
    chk("t4_head", bus.issue_rd_tag, 10);
    q = '{10, 11, 12, 13};
    nxt = 20;
    bus.issue_ready = 1'b1;
    for (int k = 0; k < 6; k++) begin
      disp(2'b00, 6'(nxt), 0, 0, 0, 0, 0, 0);
      #1;
      acc = (q.size() < 4);
      chk("t4_iv", bus.issue_valid, 1);
      chk("t4_order", bus.issue_rd_tag, q[0]);
      chk("t4_acc", bus.dispatch_ready, acc);
      void'(q.pop_front());
      if (acc) begin
        q.push_back(nxt);
        nxt++;
      end
      tick();
    end
    bus.dispatch_valid = 1'b0;
    bus.issue_ready = 1'b0;
    #1;
    chk("t4_cnt3", bus.count, q.size());
    chk("t4_head2", bus.issue_rd_tag, q[0]);

    // 5: flush
    flush = 1'b1;
    tick();
    flush = 1'b0;
    #1;
    chk("t5_count", bus.count, 0);
    chk("t5_empty", bus.empty, 1);
    chk("t5_iv", bus.issue_valid, 0);
    flush = 1'b1;
    disp(2'b00, 7, 0, 0, 0, 0, 0, 0);
    tick();
    flush = 1'b0;
    bus.dispatch_valid = 1'b0;
    #1;
    chk("t5_fd_empty", bus.empty, 1);
    chk("t5_fd_iv", bus.issue_valid, 0);

    // 6: reset during wakeup
    disp(2'b01, 40, 30, 0, 0, 0, 0, 0);
    tick();
    disp(2'b01, 41, 30, 0, 0, 0, 0, 0);
    tick();
    bus.dispatch_valid = 1'b0;
    #1;
    chk("t6_count2", bus.count, 2);
    cdb(1'b1, 30, 32'h77);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    cdb(1'b0, 0, 0);
    #1;
    chk("t6_count", bus.count, 0);
    chk("t6_iv", bus.issue_valid, 0);
    chk("t6_rs1", bus.issue_rs1_data, 0);
    disp(2'b10, 5, 1, 32'h11, 1, 2, 32'h22, 1);
    tick();
    bus.dispatch_valid = 1'b0;
    #1;
    chk("t6_v", bus.issue_valid, 1);
    chk("t6_rd", bus.issue_rd_tag, 5);
    chk("t6_rs1b", bus.issue_rs1_data, 32'h11);
    chk("t6_rs2b", bus.issue_rs2_data, 32'h22);
    drain1();
    chk("t6_empty", bus.empty, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end

endmodule
